wb_stage: RTL

//  Writeback stage of the orion pipeline; directly upstream of the register file.

---
 rtl/orion_types_pkg.sv | 17 +
 rtl/load_align.sv | 37 +++
 rtl/wb_stage.sv | 125 ++++++++++++
 3 files changed

// File: rtl/orion_types_pkg.sv
// rtl/orion_types_pkg.sv - shared orion pipeline types, widths and load funct3 codes
package orion_types_pkg;
  localparam int XLEN        = 32;
  localparam int RF_IDX_BITS = 5;

  typedef enum logic [1:0] {
    WB_ALU  = 2'd0,
    WB_LOAD = 2'd1,
    WB_PC4  = 2'd2
  } wb_src_e;

  localparam logic [2:0] LD_LB  = 3'b000;
  localparam logic [2:0] LD_LH  = 3'b001;
  localparam logic [2:0] LD_LW  = 3'b010;
  localparam logic [2:0] LD_LBU = 3'b100;
  localparam logic [2:0] LD_LHU = 3'b101;
endpackage

// File: rtl/load_align.sv
// rtl/load_align.sv - selects the addressed byte/half of a load word and extends it
module load_align
  import orion_types_pkg::*;
(
  input  logic [XLEN-1:0] word_i,
  input  logic [2:0]      funct3_i,
  input  logic [1:0]      off_i,
  output logic [XLEN-1:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word_i[7:0];
    case (off_i)
      2'd0: byte_sel = word_i[7:0];
      2'd1: byte_sel = word_i[15:8];
      2'd2: byte_sel = word_i[23:16];
      default: byte_sel = word_i[31:24];
    endcase
    // Halfword loads only look at off[1]; misalignment is trapped upstream.
    half_sel = off_i[1] ? word_i[31:16] : word_i[15:0];
  end

  always_comb begin
    data_o = word_i;
    case (funct3_i)
      LD_LB:  data_o = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      LD_LH:  data_o = {{(XLEN-16){half_sel[15]}}, half_sel};
      LD_LBU: data_o = {{(XLEN-8){1'b0}}, byte_sel};
      LD_LHU: data_o = {{(XLEN-16){1'b0}}, half_sel};
      default: data_o = word_i;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - writeback stage: holds one MEM->WB instruction, waits for loads, drives regfile write port
module wb_stage
  import orion_types_pkg::*;
#(
  parameter int CNT_W = 64
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   mem_valid_i,
  output logic                   mem_ready_o,
  input  logic [RF_IDX_BITS-1:0] mem_rd_s_i,
  input  logic                   mem_rd_we_i,
  input  logic [1:0]             mem_wb_src_i,
  input  logic [XLEN-1:0]        mem_alu_res_i,
  input  logic [XLEN-1:0]        mem_pc_i,
  input  logic [2:0]             mem_ld_funct3_i,
  input  logic [1:0]             mem_ld_off_i,
  input  logic                   dmem_rsp_valid_i,
  input  logic [XLEN-1:0]        dmem_rsp_data_i,
  output logic [RF_IDX_BITS-1:0] rf_rd_s_o,
  output logic [XLEN-1:0]        rf_rd_v_o,
  output logic                   rf_we_o,
  output logic [CNT_W-1:0]       instret_o,
  output logic                   rsp_err_o
);

  typedef enum logic [1:0] {
    S_EMPTY   = 2'd0,
    S_WAIT_LD = 2'd1,
    S_READY   = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [RF_IDX_BITS-1:0] pend_s_q;
  logic                   pend_we_q;
  logic [2:0]             pend_f3_q;
  logic [1:0]             pend_off_q;
  logic [RF_IDX_BITS-1:0] rd_s_q;
  logic [XLEN-1:0]        rd_v_q;
  logic                   rd_we_q;
  logic [CNT_W-1:0]       instret_q;
  logic                   err_q;

  logic            accept;
  logic            is_load;
  logic            rsp_in_wait;
  logic [XLEN-1:0] wb_val;
  logic [XLEN-1:0] ld_val;

  assign accept      = mem_valid_i & mem_ready_o;
  assign is_load     = (mem_wb_src_i == WB_LOAD);
  assign rsp_in_wait = dmem_rsp_valid_i & (state_q == S_WAIT_LD);
  // Source code 3 is undefined and falls back to the ALU result.
  assign wb_val      = (mem_wb_src_i == WB_PC4) ? (mem_pc_i + XLEN'(4)) : mem_alu_res_i;

  load_align u_load_align (
    .word_i   (dmem_rsp_data_i),
    .funct3_i (pend_f3_q),
    .off_i    (pend_off_q),
    .data_o   (ld_val)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= S_EMPTY;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_EMPTY, S_READY: begin
        if (accept) state_d = is_load ? S_WAIT_LD : S_READY;
        else        state_d = S_EMPTY;
      end
      S_WAIT_LD: if (dmem_rsp_valid_i) state_d = S_READY;
      default:   state_d = S_EMPTY;
    endcase
  end

  always_comb begin
    mem_ready_o = (state_q != S_WAIT_LD);
    rf_we_o     = (state_q == S_READY) & rd_we_q;
  end

  // Output registers only change when an instruction enters READY, so they hold between commits.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pend_s_q   <= '0;
      pend_we_q  <= 1'b0;
      pend_f3_q  <= '0;
      pend_off_q <= '0;
      rd_s_q     <= '0;
      rd_v_q     <= '0;
      rd_we_q    <= 1'b0;
      instret_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      if (accept) begin
        pend_s_q   <= mem_rd_s_i;
        pend_we_q  <= mem_rd_we_i;
        pend_f3_q  <= mem_ld_funct3_i;
        pend_off_q <= mem_ld_off_i;
        if (!is_load) begin
          rd_s_q  <= mem_rd_s_i;
          rd_v_q  <= wb_val;
          rd_we_q <= mem_rd_we_i;
        end
      end
      if (rsp_in_wait) begin
        rd_s_q  <= pend_s_q;
        rd_v_q  <= ld_val;
        rd_we_q <= pend_we_q;
      end
      if (dmem_rsp_valid_i && !rsp_in_wait) err_q <= 1'b1;
      if (state_q == S_READY) instret_q <= instret_q + CNT_W'(1);
    end
  end

  assign rf_rd_s_o = rd_s_q;
  assign rf_rd_v_o = rd_v_q;
  assign instret_o = instret_q;
  assign rsp_err_o = err_q;

endmodule
